// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA text terminal.
package vga_pkg;

  localparam int SCR_COLS       = 80;
  localparam int SCR_ROWS       = 25;
  localparam int TERM_FIRST_ROW = 1;

  localparam logic [15:0] BLANK_WORD = 16'h2020;

  // control codes
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // byte addresses derived from the screen geometry
  localparam logic [10:0] ROW_STEP      = 11'(SCR_COLS);
  localparam logic [10:0] CUR_HOME      = 11'(TERM_FIRST_ROW * SCR_COLS);
  localparam logic [10:0] LAST_ROW_BASE = 11'((SCR_ROWS - 1) * SCR_COLS);
  localparam logic [10:0] SCR_LAST_DST  = 11'((SCR_ROWS - 1) * SCR_COLS - 2);
  localparam logic [10:0] CLR_LAST      = 11'(SCR_ROWS * SCR_COLS - 2);
  localparam logic [6:0]  LAST_COL      = 7'(SCR_COLS - 1);

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_t;

endpackage

// File: rtl/vga_term_flash.sv
// Free-running flash prescaler: toggles flash every DIV clock cycles.
module vga_term_flash
  import vga_pkg::*;
#(
  parameter logic [23:0] DIV = 24'd5000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic flash
);

  logic [23:0] cnt;

  // count DIV cycles, then wrap and flip the flash phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      flash <= 1'b0;
    end else if (cnt == DIV - 24'd1) begin
      cnt   <= '0;
      flash <= ~flash;
    end else begin
      cnt <= cnt + 24'd1;
    end
  end

endmodule

// File: rtl/vga_term.sv
// VGA text terminal: writes a character stream into an 80x25 text buffer
// over a Wishbone master port, scrolling rows 1..24 when the cursor leaves
// the last row. Row 0 is never touched.
// Optional: define VGA_TERM_CLS_EN to make 0x0C clear the terminal area.
module vga_term
  import vga_pkg::*;
#(
  parameter logic [23:0] FLASH_DIV = 24'd5000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [7:0]  ch_i,
  input  logic        ch_valid_i,
  output logic        ch_ready_o,
  input  logic        cursor_en_i,
  input  logic        cur_block_i,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i,
  output logic [10:0] cursor_o,
  output logic        cursor_on_o,
  output logic        cursor_type_o,
  output logic        flash_o
);

  state_t      state, state_nx;
  logic [10:0] cur;     // cursor byte address
  logic [6:0]  col;     // cursor column, kept alongside cur to avoid a divide
  logic [10:0] ptr;     // scroll destination / clear address
  logic [15:0] rdat;    // word latched during the scroll read
  logic [7:0]  ch_q;    // character being written
  logic        gap;     // forces one idle bus cycle after every ack
  logic        cls;     // current CLR pass came from a form feed
  logic        ack;
  logic [10:0] adr;
  logic        at_last_row;

  assign ack         = wb_ack_i & wb_stb_o;
  assign at_last_row = (cur >= LAST_ROW_BASE);
  assign ch_ready_o  = (state == IDLE);
  assign cursor_o    = cur;
  assign wb_adr_o    = {5'b0, adr};

  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_nx;
  end

  // next state and bus outputs
  always_comb begin
    state_nx = state;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = 2'b00;
    wb_dat_o = '0;
    adr      = '0;
    case (state)
      IDLE: begin
        if (ch_valid_i) begin
          if (ch_i >= CH_SPACE)                 state_nx = PUT;
          else if (ch_i == CH_LF && at_last_row) state_nx = SCR_RD;
`ifdef VGA_TERM_CLS_EN
          else if (ch_i == CH_FF)               state_nx = CLR;
`endif
        end
      end
      PUT: begin
        wb_cyc_o = ~gap;
        wb_stb_o = ~gap;
        wb_we_o  = 1'b1;
        adr      = cur;
        wb_sel_o = cur[0] ? 2'b10 : 2'b01;
        wb_dat_o = {ch_q, ch_q};
        if (ack) state_nx = (col == LAST_COL && at_last_row) ? SCR_RD : IDLE;
      end
      SCR_RD: begin
        wb_cyc_o = ~gap;
        wb_stb_o = ~gap;
        adr      = ptr + ROW_STEP;
        wb_sel_o = 2'b11;
        if (ack) state_nx = SCR_WR;
      end
      SCR_WR: begin
        wb_cyc_o = ~gap;
        wb_stb_o = ~gap;
        wb_we_o  = 1'b1;
        adr      = ptr;
        wb_sel_o = 2'b11;
        wb_dat_o = rdat;
        if (ack) state_nx = (ptr == SCR_LAST_DST) ? CLR : SCR_RD;
      end
      CLR: begin
        wb_cyc_o = ~gap;
        wb_stb_o = ~gap;
        wb_we_o  = 1'b1;
        adr      = ptr;
        wb_sel_o = 2'b11;
        wb_dat_o = BLANK_WORD;
        if (ack && ptr == CLR_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // cursor, scroll pointer and bus bookkeeping
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cur  <= CUR_HOME;
      col  <= '0;
      ptr  <= '0;
      rdat <= '0;
      ch_q <= '0;
      gap  <= 1'b0;
      cls  <= 1'b0;
    end else begin
      gap <= ack;
      case (state)
        IDLE: begin
          if (ch_valid_i) begin
            ch_q <= ch_i;
            case (ch_i)
              CH_CR: begin
                cur <= cur - {4'b0, col};
                col <= '0;
              end
              CH_BS: begin
                if (col != '0) begin
                  cur <= cur - 11'd1;
                  col <= col - 7'd1;
                end
              end
              CH_LF: begin
                if (at_last_row) ptr <= CUR_HOME;
                else             cur <= cur + ROW_STEP;
              end
`ifdef VGA_TERM_CLS_EN
              CH_FF: begin
                ptr <= CUR_HOME;
                cls <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
        PUT: begin
          if (ack) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (at_last_row) begin
                cur <= LAST_ROW_BASE;
                ptr <= CUR_HOME;
              end else begin
                cur <= cur + 11'd1;
              end
            end else begin
              cur <= cur + 11'd1;
              col <= col + 7'd1;
            end
          end
        end
        SCR_RD: if (ack) rdat <= wb_dat_i;
        SCR_WR: begin
          if (ack) ptr <= (ptr == SCR_LAST_DST) ? LAST_ROW_BASE : ptr + 11'd2;
        end
        CLR: begin
          if (ack) begin
            if (ptr == CLR_LAST) begin
              if (cls) begin
                cur <= CUR_HOME;
                col <= '0;
              end
              cls <= 1'b0;
            end else begin
              ptr <= ptr + 11'd2;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // cursor attributes to the text adapter; cursor hidden while busy
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cursor_on_o   <= 1'b0;
      cursor_type_o <= 1'b0;
    end else begin
      cursor_on_o   <= cursor_en_i & (state == IDLE);
      cursor_type_o <= cur_block_i;
    end
  end

  vga_term_flash #(.DIV(FLASH_DIV)) u_flash (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n_i),
    .flash (flash_o)
  );

endmodule

// File: tb/tb_vga_term.sv
// Directed bench for vga_term against a one-cycle-ack Wishbone memory.
module tb_vga_term;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch = '0;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic        cursor_en = 1'b1;
  logic        cur_block = 1'b1;
  logic [15:0] adr, dat_o;
  logic [15:0] dat_i = '0;
  logic        cyc, stb, we;
  logic [1:0]  sel;
  logic        ack = 1'b0;
  logic [10:0] cursor;
  logic        cursor_on, cursor_type, flash;

  always #5 clk = ~clk;

  vga_term #(.FLASH_DIV(24'd4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .ch_i(ch), .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
    .cursor_en_i(cursor_en), .cur_block_i(cur_block),
    .wb_adr_o(adr), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_sel_o(sel),
    .wb_ack_i(ack),
    .cursor_o(cursor), .cursor_on_o(cursor_on),
    .cursor_type_o(cursor_type), .flash_o(flash)
  );

  // memory slave: ack one cycle after strobe, then drop for a cycle
  logic [15:0] mem [1000];
  logic [15:0] snap [1000];
  logic        fill = 1'b0;
  int          wr_cnt = 0, rd_cnt = 0, cyc_cnt = 0;
  logic [15:0] last_adr = '0, last_dat = '0;
  logic [1:0]  last_sel = '0;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 1000; i++) mem[i] <= 16'(i * 7 + 3);
    end
    if (cyc) cyc_cnt <= cyc_cnt + 1;
    if (stb && !ack) begin
      ack <= 1'b1;
      if (we) begin
        if (sel[0]) mem[adr[10:1]][7:0]  <= dat_o[7:0];
        if (sel[1]) mem[adr[10:1]][15:8] <= dat_o[15:8];
        wr_cnt   <= wr_cnt + 1;
        last_adr <= adr;
        last_sel <= sel;
        last_dat <= dat_o;
      end else begin
        dat_i  <= mem[adr[10:1]];
        rd_cnt <= rd_cnt + 1;
      end
    end else begin
      ack <= 1'b0;
    end
  end

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // offer one character; optionally wait until the block is idle again
  task automatic send(input logic [7:0] c, input bit wait_done, output int lat);
    int t;
    t = 0;
    while (!ch_ready && t < 20000) begin @(posedge clk); #1; t++; end
    if (!ch_ready) chk("ready_timeout_pre", 0, 1);
    ch = c; ch_valid = 1'b1;
    @(posedge clk); #1;
    ch_valid = 1'b0;
    lat = 0;
    if (wait_done) begin
      while (!ch_ready && lat < 20000) begin @(posedge clk); #1; lat++; end
      if (!ch_ready) chk("ready_timeout_post", 0, 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int lat, w0, r0, c0, errs;
  logic [11:0] fobs;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cursor", cursor, 80);
    chk("rst_cyc", {cyc, stb, we}, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_sel", sel, 0);
    chk("rst_attr", {cursor_on, cursor_type, flash}, 0);

    // release, then watch flash with FLASH_DIV=4
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      fobs[k-1] = flash;
      if (k == 1) begin
        chk("ready_after_rst", ch_ready, 1);
        chk("cursor_on_after_rst", cursor_on, 1);
        chk("cursor_type", cursor_type, 1);
        chk("cyc_after_rst", cyc, 0);
      end
    end
    chk("flash_pattern", fobs, 12'h878);

    // two printable characters
    w0 = wr_cnt;
    send(8'h41, 1, lat);
    chk("put_lat", lat, 2);
    chk("put_wr", wr_cnt - w0, 1);
    chk("put_adr", last_adr, 80);
    chk("put_sel", last_sel, 2'b01);
    chk("put_dat_lo", last_dat[7:0], 8'h41);
    chk("put_cursor", cursor, 81);
    send(8'h42, 1, lat);
    chk("put2_adr", last_adr, 81);
    chk("put2_sel", last_sel, 2'b10);
    chk("put2_dat_hi", last_dat[15:8], 8'h42);
    chk("put2_cursor", cursor, 82);

    // control codes at row 5 col 37
    do_reset();
    for (int i = 0; i < 4; i++) send(CH_LF_T(), 1, lat);
    for (int i = 0; i < 37; i++) send(8'h78, 1, lat);
    chk("pos437", cursor, 437);
    c0 = cyc_cnt;
    send(8'h0D, 1, lat);
    chk("cr_cursor", cursor, 400);
    chk("cr_lat", lat, 0);
    send(8'h08, 1, lat);
    chk("bs_col0", cursor, 400);
    send(8'h0A, 1, lat);
    chk("lf_cursor", cursor, 480);
    send(8'h1B, 1, lat);
    chk("esc_cursor", cursor, 480);
    chk("ctl_no_cyc", cyc_cnt - c0, 0);
    send(8'h61, 1, lat);
    send(8'h08, 1, lat);
    chk("bs_cursor", cursor, 480);

    // form feed
    w0 = wr_cnt; c0 = cyc_cnt;
    send(8'h0C, 1, lat);
`ifdef VGA_TERM_CLS_EN
    chk("ff_wr", wr_cnt - w0, 960);
    chk("ff_cursor", cursor, 80);
    chk("ff_first", mem[40], 16'h2020);
    chk("ff_last", mem[999], 16'h2020);
`else
    chk("ff_no_cyc", cyc_cnt - c0, 0);
    chk("ff_cursor", cursor, 480);
`endif

    // scroll from cursor 1999
    do_reset();
    @(negedge clk) fill = 1'b1;
    @(negedge clk) fill = 1'b0;
    for (int i = 0; i < 23; i++) send(8'h0A, 1, lat);
    chk("pos1920", cursor, 1920);
    for (int i = 0; i < 79; i++) send(8'(8'h30 + (i % 40)), 1, lat);
    chk("pos1999", cursor, 1999);
    for (int i = 0; i < 1000; i++) snap[i] = mem[i];
    snap[999][15:8] = 8'h5A;
    w0 = wr_cnt; r0 = rd_cnt;
    send(8'h5A, 1, lat);
    chk("scr_cursor", cursor, 1920);
    chk("scr_wr", wr_cnt - w0, 961);
    chk("scr_rd", rd_cnt - r0, 920);
    errs = 0;
    for (int w = 0; w < 40; w++)    if (mem[w] !== snap[w]) errs++;
    for (int w = 40; w < 960; w++)  if (mem[w] !== snap[w + 40]) errs++;
    for (int w = 960; w < 1000; w++) if (mem[w] !== 16'h2020) errs++;
    chk("scr_mem_errs", errs, 0);
    chk("scr_row23_tail", mem[959], {8'h5A, snap[999][7:0]});

    // LF on the last row scrolls; reset mid-scroll aborts
    do_reset();
    for (int i = 0; i < 23; i++) send(8'h0A, 1, lat);
    send(8'h0A, 0, lat);
    repeat (100) @(posedge clk);
    #1;
    chk("scr_busy", ch_ready, 0);
    chk("scr_cursor_hidden", cursor_on, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_cyc", cyc, 0);
    chk("abort_cursor", cursor, 80);
    chk("abort_ready", ch_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  function automatic logic [7:0] CH_LF_T();
    return 8'h0A;
  endfunction

endmodule

// File: doc/vga_term.md
VGA_TERM -- requirements
Module: vga_term

Interface
REQ-001 SHALL have parameter FLASH_DIV, default 24'd5000000, meaning the wb_clk_i cycles per flash_o half-period.
REQ-002 SHALL have port wb_clk_i  in  1  the single clock, shared with the text adapter bus.
REQ-003 SHALL have port wb_rst_n_i  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports ch_i  in  8 (character code), ch_valid_i  in  1 (character offered) and ch_ready_o  out  1 (character accepted).
REQ-005 SHALL have ports cursor_en_i  in  1 (cursor wanted) and cur_block_i  in  1 (block cursor wanted).
REQ-006 SHALL have Wishbone master ports wb_adr_o  out  16 (byte address), wb_dat_o  out  16, wb_dat_i  in  16, wb_cyc_o  out  1, wb_stb_o  out  1, wb_we_o  out  1, wb_sel_o  out  2 and wb_ack_i  in  1.
REQ-007 SHALL have ports cursor_o  out  11 (byte address of the cursor), cursor_on_o  out  1, cursor_type_o  out  1 and flash_o  out  1, all feeding the text adapter.

Function
REQ-008 Screen model SHALL be 80x25 bytes, where byte address = row*80 + col; row 0 is the service line and is never written; the terminal area is rows 1..24 (addresses 80..1999).
REQ-009 A character SHALL be accepted on a cycle where ch_valid_i&ch_ready_o; ch_ready_o SHALL equal (state==IDLE).
REQ-010 FSM states SHALL be IDLE, PUT, SCR_RD, SCR_WR, CLR; every bus state SHALL hold cyc/stb/adr/dat/sel/we stable until wb_ack_i, then deassert cyc/stb for at least one cycle.
REQ-011 Code 0x20..0xFF SHALL go to PUT: one write, adr=cursor, sel=01/dat[7:0]=ch when cursor[0]=0, sel=10/dat[15:8]=ch when cursor[0]=1; on ack col SHALL increment, and at col 79 SHALL wrap to col 0 of the next row.
REQ-012 0x0D (CR) SHALL set col=0; 0x08 (BS) SHALL decrement col if col>0, else do nothing; 0x0A (LF) SHALL advance the row; all of these SHALL produce no bus cycle and return to IDLE the next cycle.
REQ-013 Any other code in 0x00..0x1F SHALL be consumed and ignored.
REQ-014 A row advance from row 24 SHALL keep row=24 and start a scroll: word copy, dst=80..1918 step 2, src=dst+80, SCR_RD (we=0, sel=11, latch wb_dat_i at ack) then SCR_WR (sel=11) at dst; this is 920 pairs.
REQ-015 After the scroll copy, CLR SHALL write 0x2020 to the 40 words 1920..1998 (sel=11), then return to IDLE.
REQ-016 cursor_o SHALL be registered and updated on the cycle the operation completes; it SHALL always lie in 80..1999.
REQ-017 cursor_on_o SHALL be cursor_en_i & (state==IDLE), registered; the cursor is hidden during PUT/scroll/clear.
REQ-018 cursor_type_o SHALL be cur_block_i, registered.
REQ-019 flash_o SHALL toggle every FLASH_DIV cycles from a free-running counter that wraps to 0, independent of the FSM.
REQ-020 A printable character at col 79/row 24 SHALL perform PUT, then scroll, and end at cursor 1920.

Reset
REQ-021 While wb_rst_n_i=0 the block SHALL hold: state IDLE, cursor_o=80 (row 1, col 0), cyc/stb/we=0, adr/dat_o=0, sel=00, cursor_on_o=0, cursor_type_o=0, flash_o=0, flash counter 0.
REQ-022 Reset asserted mid-scroll SHALL abort immediately with cyc dropped; memory contents are left partially scrolled; no resume.

Configuration
REQ-023 With VGA_TERM_CLS_EN defined, 0x0C (FF) SHALL write 0x2020 to words 80..1998 (960 writes) via CLR, then set cursor 80.
REQ-024 Without VGA_TERM_CLS_EN, 0x0C SHALL be ignored like any other control code.

Structure
REQ-025 A shared package vga_pkg SHALL hold SCR_COLS=80, SCR_ROWS=25, TERM_FIRST_ROW=1, BLANK_WORD=16'h2020, the control-code constants and the state enum.
REQ-026 One sub-module, vga_term_flash (flash prescaler), SHALL be instantiated; everything else stays flat.

Verification
REQ-027 Release reset -> cursor_o=80, ch_ready_o=1, wb_cyc_o=0, cursor_on_o=cursor_en_i one cycle later.
REQ-028 Send 0x41 at cursor 80 against a 1-cycle-ack slave -> one write adr=80, sel=01, dat[7:0]=41; cursor_o=81; ch_ready_o back high on the cycle after ack; then send 0x42 -> sel=10, dat[15:8]=42, cursor 82.
REQ-029 Cursor 1999, send 0x5A -> write at 1999, then 920 read/write pairs with row k+1 data landing in row k, then 40 writes of 2020 at 1920..1998; cursor_o=1920.
REQ-030 Cursor 437 (row 5, col 37), send 0x0D -> cursor 400, no cyc; then 0x08 -> 400 unchanged; then 0x0A -> 480.
REQ-031 With VGA_TERM_CLS_EN, send 0x0C -> 960 writes of 2020 and cursor 80; without it -> no bus activity and cursor unchanged.
REQ-032 FLASH_DIV=4 -> flash_o toggles every 4 cycles; reset asserted mid-scroll -> cyc_o=0 same cycle, cursor_o=80.
